// File: rtl/rs_pkg.sv
// rs_pkg: op encodings, default widths, entry type and priority encoder for the reservation station
package rs_pkg;
  localparam int ROB_TAG_W_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF = 6;
  localparam int RS_MAX = 64;
  localparam logic [OP_W_DEF-1:0] OP_LUI = 6'd0, OP_AUIPC = 6'd1, OP_JAL = 6'd2, OP_JALR = 6'd3,
    OP_BEQ = 6'd4, OP_BNE = 6'd5, OP_BLT = 6'd6, OP_BGE = 6'd7, OP_BLTU = 6'd8, OP_BGEU = 6'd9,
    OP_LB = 6'd10, OP_LH = 6'd11, OP_LW = 6'd12, OP_LBU = 6'd13, OP_LHU = 6'd14,
    OP_SB = 6'd15, OP_SH = 6'd16, OP_SW = 6'd17,
    OP_ADDI = 6'd18, OP_SLTI = 6'd19, OP_SLTIU = 6'd20, OP_XORI = 6'd21, OP_ORI = 6'd22,
    OP_ANDI = 6'd23, OP_SLLI = 6'd24, OP_SRLI = 6'd25, OP_SRAI = 6'd26,
    OP_ADD = 6'd27, OP_SUB = 6'd28, OP_SLL = 6'd29, OP_SLT = 6'd30, OP_SLTU = 6'd31,
    OP_XOR = 6'd32, OP_SRL = 6'd33, OP_SRA = 6'd34, OP_OR = 6'd35, OP_AND = 6'd36;
  typedef logic [RS_MAX-1:0] rs_vec_t;
  typedef struct packed {
    logic                     busy;
    logic [OP_W_DEF-1:0]      op;
    logic [DATA_W_DEF-1:0]    vj;
    logic [DATA_W_DEF-1:0]    vk;
    logic [ROB_TAG_W_DEF-1:0] qj;
    logic [ROB_TAG_W_DEF-1:0] qk;
    logic                     j;
    logic                     k;
    logic [DATA_W_DEF-1:0]    imm;
    logic [DATA_W_DEF-1:0]    pc;
    logic [ROB_TAG_W_DEF-1:0] dest;
  } rs_entry_t;
  // index of the lowest set bit, -1 when none is set
  function automatic int lowest_set(input rs_vec_t v);
    int r = -1;
    for (int i = RS_MAX - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/rs_alu.sv
// rs_alu: combinational integer/branch ALU for ops leaving the reservation station
module rs_alu
  import rs_pkg::*;
(
  input  logic [OP_W_DEF-1:0]   op,
  input  logic [DATA_W_DEF-1:0] vj,
  input  logic [DATA_W_DEF-1:0] vk,
  input  logic [DATA_W_DEF-1:0] imm,
  input  logic [DATA_W_DEF-1:0] pc,
  output logic [DATA_W_DEF-1:0] value,
  output logic [DATA_W_DEF-1:0] new_pc,
  output logic                  is_jalr
);
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign new_pc = (vj + imm) & ~32'd1;
  assign is_jalr = op == OP_JALR;
  // result select; upper-immediate and link values arrive precomputed in imm
  always_comb begin
    value = '0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: value = imm;
      OP_BEQ:   value = {31'b0, vj == vk};
      OP_BNE:   value = {31'b0, vj != vk};
      OP_BLT:   value = {31'b0, $signed(vj) < $signed(vk)};
      OP_BGE:   value = {31'b0, $signed(vj) >= $signed(vk)};
      OP_BLTU:  value = {31'b0, vj < vk};
      OP_BGEU:  value = {31'b0, vj >= vk};
      OP_ADDI:  value = vj + imm;
      OP_SLTI:  value = {31'b0, $signed(vj) < $signed(imm)};
      OP_SLTIU: value = {31'b0, vj < imm};
      OP_XORI:  value = vj ^ imm;
      OP_ORI:   value = vj | imm;
      OP_ANDI:  value = vj & imm;
      OP_SLLI:  value = vj << imm[4:0];
      OP_SRLI:  value = vj >> imm[4:0];
      OP_SRAI:  value = $signed(vj) >>> imm[4:0];
      OP_ADD:   value = vj + vk;
      OP_SUB:   value = vj - vk;
      OP_SLL:   value = vj << vk[4:0];
      OP_SLT:   value = {31'b0, $signed(vj) < $signed(vk)};
      OP_SLTU:  value = {31'b0, vj < vk};
      OP_XOR:   value = vj ^ vk;
      OP_SRL:   value = vj >> vk[4:0];
      OP_SRA:   value = $signed(vj) >>> vk[4:0];
      OP_OR:    value = vj | vk;
      OP_AND:   value = vj & vk;
      default:  value = '0;
    endcase
  end
endmodule

// File: rtl/reservation_station_v2.sv
// reservation_station_v2: buffers decoded ops, snoops the CDB for operands, issues the lowest ready entry
module reservation_station_v2
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          to_rs,
  input  logic [OP_W-1:0]               op_type,
  input  logic                          j_in,
  input  logic                          k_in,
  input  logic [DATA_W-1:0]             vj_in,
  input  logic [DATA_W-1:0]             vk_in,
  input  logic [ROB_TAG_W-1:0]          qj_in,
  input  logic [ROB_TAG_W-1:0]          qk_in,
  input  logic [ROB_TAG_W-1:0]          dest_in,
  input  logic [DATA_W-1:0]             imm_in,
  input  logic [DATA_W-1:0]             inst_pc,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_value,
  output logic                          full,
  output logic [$clog2(RS_DEPTH):0]     count,
  output logic                          has_result,
  output logic [DATA_W-1:0]             value,
  output logic [ROB_TAG_W-1:0]          dest_out,
  output logic                          is_jalr,
  output logic [DATA_W-1:0]             new_PC
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  rs_entry_t r_ent [RS_DEPTH];
  rs_entry_t w_nxt [RS_DEPTH];
  rs_entry_t w_new;
  rs_vec_t w_free_v, w_rdy_v;
  int w_free_i, w_rdy_i;
  logic [IDX_W-1:0] w_rdy_idx;
  logic w_ins, w_iss, w_jalr;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] w_val, w_npc;
  logic [DATA_W:0] w_nj, w_nk;
  logic [DATA_W:0] w_sj [RS_DEPTH];
  logic [DATA_W:0] w_sk [RS_DEPTH];
  // {hit, value} for a tag across all channels; the lowest matching channel wins
  function automatic logic [DATA_W:0] snoop(input logic [ROB_TAG_W-1:0] t);
    logic [DATA_W:0] r = '0;
    for (int c = CDB_PORTS - 1; c >= 0; c--)
      if (cdb_valid[c] && cdb_tag[c*ROB_TAG_W +: ROB_TAG_W] == t) r = {1'b1, cdb_value[c*DATA_W +: DATA_W]};
    return r;
  endfunction
  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_snoop
    assign w_sj[g] = snoop(r_ent[g].qj);
    assign w_sk[g] = snoop(r_ent[g].qk);
  end
  // free and ready vectors feeding the shared priority encoder
  always_comb begin
    w_free_v = '0;
    w_rdy_v = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_free_v[i] = !r_ent[i].busy;
      w_rdy_v[i] = r_ent[i].busy && r_ent[i].j && r_ent[i].k;
    end
  end
  assign w_free_i = lowest_set(w_free_v);
  assign w_rdy_i = lowest_set(w_rdy_v);
  assign w_rdy_idx = IDX_W'(w_rdy_i);
  assign w_ins = to_rs && !full;
  assign w_iss = w_rdy_i >= 0;
  assign w_cnt_nxt = count + CNT_W'(w_ins) - CNT_W'(w_iss);
  assign w_nj = snoop(qj_in);
  assign w_nk = snoop(qk_in);
  assign w_new = '{busy: 1'b1, op: op_type, vj: j_in ? vj_in : w_nj[DATA_W-1:0],
                   vk: k_in ? vk_in : w_nk[DATA_W-1:0], qj: qj_in, qk: qk_in,
                   j: j_in || w_nj[DATA_W], k: k_in || w_nk[DATA_W],
                   imm: imm_in, pc: inst_pc, dest: dest_in};
  // per-entry next state: wakeup, then issue release, then insert into the chosen free slot
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_nxt[i] = r_ent[i];
      if (r_ent[i].busy && !r_ent[i].j && w_sj[i][DATA_W]) begin
        w_nxt[i].j = 1'b1;
        w_nxt[i].vj = w_sj[i][DATA_W-1:0];
      end
      if (r_ent[i].busy && !r_ent[i].k && w_sk[i][DATA_W]) begin
        w_nxt[i].k = 1'b1;
        w_nxt[i].vk = w_sk[i][DATA_W-1:0];
      end
      if (w_iss && i == w_rdy_i) w_nxt[i].busy = 1'b0;
      if (w_ins && i == w_free_i) w_nxt[i] = w_new;
    end
  end
  rs_alu u_alu (
    .op(r_ent[w_rdy_idx].op), .vj(r_ent[w_rdy_idx].vj), .vk(r_ent[w_rdy_idx].vk),
    .imm(r_ent[w_rdy_idx].imm), .pc(r_ent[w_rdy_idx].pc),
    .value(w_val), .new_pc(w_npc), .is_jalr(w_jalr)
  );
  // entry array, occupancy and registered result port; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_DEPTH; i++) r_ent[i].busy <= 1'b0;
      count <= '0;
      full <= 1'b0;
      has_result <= 1'b0;
      is_jalr <= 1'b0;
      value <= '0;
      dest_out <= '0;
      new_PC <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < RS_DEPTH; i++) r_ent[i].busy <= 1'b0;
        count <= '0;
        full <= 1'b0;
        has_result <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= w_nxt[i];
        count <= w_cnt_nxt;
        full <= w_cnt_nxt == CNT_W'(RS_DEPTH);
        has_result <= w_iss;
        if (w_iss) begin
          value <= w_val;
          dest_out <= r_ent[w_rdy_idx].dest;
          is_jalr <= w_jalr;
          new_PC <= w_npc;
        end
      end
    end
  end
endmodule

// File: doc/reservation_station_v2.md
Name: reservation_station_v2

Overview:
Parametrised successor to the single-ALU reservation station. It buffers decoded integer and branch ops until their operands are ready, snooping CDB_PORTS common-data-bus channels for operand wakeup. Each cycle it issues the lowest-index ready entry to an internal ALU and returns a registered result, tagged by ROB index, to the ROB/CDB. It sits between the Decoder and the ROB and adds full/count backpressure and a mispredict flush.

Parameters:
RS_DEPTH, 16, number of entries; power of two, at least 2
ROB_TAG_W, 4, ROB index width (qj/qk/dest tags)
DATA_W, 32, operand/result width; fixed at 32 for RV32I
OP_W, 6, op_type width
CDB_PORTS, 2, number of broadcast channels snooped for wakeup

Ports:
clk_in  in  1  clock; all logic on the rising edge
rst_n_in  in  1  synchronous active-low reset
rdy_in  in  1  low = pause; every register holds
flush_in  in  1  mispredict flush; clears all entries
to_rs  in  1  insert request from Decoder
op_type  in  OP_W  op encoding from shared package
j_in, k_in  in  1 each  operand j/k already valid
vj_in, vk_in  in  DATA_W each  operand values, used when j/k set
qj_in, qk_in  in  ROB_TAG_W each  producer tags, used when j/k clear
dest_in  in  ROB_TAG_W  ROB entry receiving the result
imm_in  in  DATA_W  immediate or precomputed value
inst_pc  in  DATA_W  instruction PC
cdb_valid  in  CDB_PORTS  per-channel broadcast valid
cdb_tag  in  CDB_PORTS*ROB_TAG_W  packed tags; channel c at [c*W +: W]
cdb_value  in  CDB_PORTS*DATA_W  packed values
full  out  1  registered; count == RS_DEPTH
count  out  $clog2(RS_DEPTH)+1  occupied entries
has_result  out  1  one-cycle result pulse
value  out  DATA_W  result
dest_out  out  ROB_TAG_W  ROB tag of result
is_jalr  out  1  qualifies new_PC
new_PC  out  DATA_W  jalr target

Behaviour:
- Reset (rst_n_in low at edge): all busy=0, count=0, full=0, has_result=0, is_jalr=0, value=0, dest_out=0, new_PC=0. Reset overrides rdy_in and flush_in.
- rdy_in low: all state and outputs hold. No insert, wakeup or issue occurs.
- Priority at an active edge: reset, then flush, then normal operation.
- Flush: all busy=0, count=0, full=0, has_result=0. A to_rs in the same cycle is dropped.
- Insert: to_rs with full=0 writes the lowest-index free entry. to_rs with full=1 is a protocol violation; the request is dropped and state is unchanged.
- Insert bypass: an incoming operand with j/k=0 and a matching valid CDB tag that cycle is stored as valid with the CDB value.
- Wakeup: each busy entry with j=0 and qj==cdb_tag[c] on a valid channel sets j=1 and vj=cdb_value[c]; likewise for k.
  - If several channels match, the lowest channel index wins.
- Issue: select the lowest-index entry with busy&j&k, based on registered state. A woken entry therefore becomes eligible the cycle after the wakeup.
  - Selected entry: busy cleared, has_result=1 next cycle, dest_out=dest.
  - No eligible entry: has_result=0.
  - Latency: at least 1 cycle from insert (operands ready) to has_result.
  - A freed slot is reusable on the following cycle.
- count: next = count + insert - issue; a simultaneous insert and issue leaves count unchanged. full is derived from the next count.
- ALU (op codes as today):
  - lui/auipc/jal: value=imm (decoder precomputes).
  - jalr: value=imm, new_PC=(vj+imm)&~1, is_jalr=1; is_jalr=0 for all other ops.
  - Branches beq..bgeu (4–9): value=1 if taken, else 0.
  - Immediate/register ALU ops 18–36: shift amount uses [4:0] only; signed compares and sra use $signed.
  - Undefined op: value=0, still retired (has_result=1).
- Arithmetic is 32-bit wrap-around with no overflow flag.

Decomposition:
- Shared package rs_pkg: OP_* localparams (0–36, same numbering), ROB_TAG_W and DATA_W defaults, and an entry struct/typedef (busy, op, vj, vk, qj, qk, j, k, imm, pc, dest).
- Sub-module rs_alu: purely combinational (op, vj, vk, imm, pc) → (value, new_pc, is_jalr).
- A priority encoder function, shared by free-slot search and ready select, lives in rs_pkg.

Test Plan:
- Reset, then insert addi (op18) with vj=5, imm=7, dest=3, j=k=1 → has_result=1 one cycle later, value=12, dest_out=3, count back to 0.
- Insert add with qj=2 (j=0), vk=1; next cycle cdb_valid[1]=1, tag=2, value=40 → has_result one cycle after the wakeup with value=41; channel 0 with tag 2 simultaneously carrying 9 → value=10.
- Fill all 16 entries with blocked ops → full=1, count=16; a 17th to_rs is dropped; one CDB wakeup → issue, full=0 next cycle, and a new insert lands in the freed index.
- Flush while 5 entries are busy and to_rs=1 → count=0, has_result=0, no stale results in later cycles.
- jalr with vj=0x1001, imm=4 → new_PC=0x1004, is_jalr=1; bltu with vj=1, vk=0xFFFFFFFF → value=1; blt with the same operands → value=0; sra with 0x80000000 by vk=33 → 0xC0000000.
- rdy_in low for 3 cycles with a ready entry → no issue and count held; issue occurs on the first cycle rdy_in is high.
